// File: rtl/eq_pkg.sv
// Shared constants and FSM state type for the coefficient write path.
// Frame geometry: SYNC, N_BANDS*COEFF_BYTES data bytes, XOR checksum.
package eq_pkg;

    localparam int         N_BANDS     = 8;
    localparam int         COEFF_W     = 16;
    localparam logic [7:0] SYNC_BYTE   = 8'hA5;
    localparam int         BAND_W      = $clog2(N_BANDS);
    localparam int         COEFF_BYTES = COEFF_W / 8;

    typedef enum logic [1:0] {
        IDLE,
        RX_DATA,
        CHECK,
        WAIT_ACK
    } state_e;

endpackage

// File: rtl/frame_checksum_xor.sv
// Running 8-bit XOR over frame data bytes with clear and compare.
// Ports: clk, rst, en_i (clock enable), clr_i, acc_i, data_i, match_o.
module frame_checksum_xor (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic       clr_i,
    input  logic       acc_i,
    input  logic [7:0] data_i,
    output logic       match_o
);

    logic [7:0] sum_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= 8'h00;
        end else if (en_i) begin
            if (clr_i) begin
                sum_q <= 8'h00;
            end else if (acc_i) begin
                sum_q <= sum_q ^ data_i;
            end
        end
    end

    // Compared against the byte on the bus, i.e. the checksum byte.
    assign match_o = (sum_q == data_i);

endmodule

// File: rtl/coeff_write_sequencer.sv
// Parses SYNC/coeff/checksum byte frames, writes shadow coeff registers,
// then holds o_write_done until i_coeffs_en or timeout.
// Ports: clk, rst, clk_enable, i_rx_valid, i_rx_byte, i_coeffs_en,
//        o_band_addr, o_coeff_data, o_coeff_we, o_write_done, o_busy, o_frame_err.
module coeff_write_sequencer
    import eq_pkg::*;
#(
    parameter int ACK_TIMEOUT = 4096
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clk_enable,
    input  logic               i_rx_valid,
    input  logic [7:0]         i_rx_byte,
    input  logic               i_coeffs_en,
    output logic [BAND_W-1:0]  o_band_addr,
    output logic [COEFF_W-1:0] o_coeff_data,
    output logic               o_coeff_we,
    output logic               o_write_done,
    output logic               o_busy,
    output logic               o_frame_err
);

    localparam int BCNT_W = (COEFF_BYTES > 1) ? $clog2(COEFF_BYTES) : 1;
    localparam int TMO_W  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    state_e             state_q, state_d;
    logic [COEFF_W-1:0] shift_q, shift_d;
    logic [BCNT_W-1:0]  bcnt_q, bcnt_d;
    logic [BAND_W-1:0]  wcnt_q, wcnt_d;
    logic [BAND_W-1:0]  addr_q, addr_d;
    logic [COEFF_W-1:0] data_q, data_d;
    logic               we_q, we_d;
    logic               err_q, err_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               ck_clr, ck_acc, ck_match;

    frame_checksum_xor u_cksum (
        .clk     (clk),
        .rst     (rst),
        .en_i    (clk_enable),
        .clr_i   (ck_clr),
        .acc_i   (ck_acc),
        .data_i  (i_rx_byte),
        .match_o (ck_match)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            bcnt_q  <= '0;
            wcnt_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            tmo_q   <= '0;
        end else if (clk_enable) begin
            state_q <= state_d;
            shift_q <= shift_d;
            bcnt_q  <= bcnt_d;
            wcnt_q  <= wcnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            we_q    <= we_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bcnt_d  = bcnt_q;
        wcnt_d  = wcnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        // Strobe self-clears after one enabled cycle.
        we_d    = 1'b0;
        err_d   = err_q;
        tmo_d   = tmo_q;
        ck_clr  = 1'b0;
        ck_acc  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (i_rx_valid && i_rx_byte == SYNC_BYTE) begin
                    state_d = RX_DATA;
                    bcnt_d  = '0;
                    wcnt_d  = '0;
                    err_d   = 1'b0;
                    ck_clr  = 1'b1;
                end
            end
            RX_DATA: begin
                if (i_rx_valid) begin
                    ck_acc  = 1'b1;
                    shift_d = (shift_q << 8) | COEFF_W'(i_rx_byte);
                    if (bcnt_q == BCNT_W'(COEFF_BYTES - 1)) begin
                        bcnt_d = '0;
                        we_d   = 1'b1;
                        data_d = shift_d;
                        addr_d = wcnt_q;
                        wcnt_d = wcnt_q + 1'b1;
                        if (wcnt_q == BAND_W'(N_BANDS - 1)) begin
                            state_d = CHECK;
                        end
                    end else begin
                        bcnt_d = bcnt_q + 1'b1;
                    end
                end
            end
            CHECK: begin
                if (i_rx_valid) begin
                    if (ck_match) begin
                        state_d = WAIT_ACK;
                        tmo_d   = '0;
                    end else begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end
                end
            end
            WAIT_ACK: begin
                // Stray byte is dropped but flagged.
                if (i_rx_valid) begin
                    err_d = 1'b1;
                end
                if (i_coeffs_en) begin
                    state_d = IDLE;
                end else if (tmo_q == TMO_W'(ACK_TIMEOUT - 1)) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_band_addr  = addr_q;
    assign o_coeff_data = data_q;
    assign o_coeff_we   = we_q;
    assign o_write_done = (state_q == WAIT_ACK);
    assign o_busy       = (state_q != IDLE);
    assign o_frame_err  = err_q;

endmodule
